// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - per-bit rising/falling/either edge detector with one-cycle history
// Optional two-flop input synchronizer when EDGE_DETECTOR_SYNC_EN is defined.
module edge_detector #(
  parameter int WID = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [WID-1:0] i,
  output logic [WID-1:0] pe,
  output logic [WID-1:0] ne,
  output logic [WID-1:0] ee
);

  logic [WID-1:0] src;
  logic [WID-1:0] hist_q;
  logic [WID-1:0] hist_d;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic [WID-1:0] s1_q;
  logic [WID-1:0] s2_q;

  // Synchronizer runs every clock; ce only qualifies the history capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i;
      s2_q <= s1_q;
    end
  end

  assign src = s2_q;
`else
  assign src = i;
`endif

  assign hist_d = ce ? src : hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // hist is already 0 in reset, but the live input may be high, so mask explicitly.
  assign pe = rst ? '0 : (src & ~hist_q);
  assign ne = rst ? '0 : (~src & hist_q);
  assign ee = rst ? '0 : (src ^ hist_q);

endmodule

// File: tb/tb_edge_detector.sv
// tb/tb_edge_detector.sv - self-checking bench for edge_detector (WID=4)
module tb_edge_detector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic [W-1:0] i;
  logic [W-1:0] pe;
  logic [W-1:0] ne;
  logic [W-1:0] ee;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  edge_detector #(.WID(W)) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .i  (i),
    .pe (pe),
    .ne (ne),
    .ee (ee)
  );

  typedef struct {
    logic         r;
    logic         c;
    logic [W-1:0] v;
    logic [W-1:0] p;
    logic [W-1:0] n;
    logic [W-1:0] e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic [W-1:0] v,
                     input logic [W-1:0] p, input logic [W-1:0] n, input logic [W-1:0] e);
    vec_t x;
    x.r = r; x.c = c; x.v = v; x.p = p; x.n = n; x.e = e;
    tbl.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hist is the detector's view of the input at the last
  // ce-qualified clock since reset; the view is i itself, or i as sampled two
  // clocks back when the synchronizer is built in.
  logic [W-1:0] m_hist;
  logic [W-1:0] m_samp[$];

  task automatic m_reset();
    m_hist = '0;
    m_samp = {};
    m_samp.push_back('0);
    m_samp.push_back('0);
  endtask

  function automatic logic [W-1:0] m_src();
`ifdef EDGE_DETECTOR_SYNC_EN
    return m_samp[0];
`else
    return i;
`endif
  endfunction

  task automatic m_edge();
    logic [W-1:0] s;
    s = m_src();
    if (rst) begin
      m_reset();
    end else begin
      if (ce) m_hist = s;
      m_samp.push_back(i);
      void'(m_samp.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    i   = '0;
    m_reset();

`ifndef EDGE_DETECTOR_SYNC_EN
    // reset, rise, fall
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // vector changes
    add(0, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0101);
    add(0, 1, 4'b0011, 4'b0010, 4'b0100, 4'b0110);
    add(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    // clock-enable hold
    add(0, 0, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
    add(0, 0, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
    add(0, 0, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
    add(0, 0, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
    add(0, 1, 4'b1011, 4'b1000, 4'b0000, 4'b1000);
    add(0, 1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
    // reset with input high
    add(0, 1, 4'b1111, 4'b0100, 4'b0000, 4'b0100);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      rst = tbl[k].r;
      ce  = tbl[k].c;
      i   = tbl[k].v;
      #2;
      check($sformatf("tbl%0d pe", k), pe, tbl[k].p);
      check($sformatf("tbl%0d ne", k), ne, tbl[k].n);
      check($sformatf("tbl%0d ee", k), ee, tbl[k].e);
    end

    // asynchronous reset mid-cycle, released before any clock edge
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst pe", pe, 4'b0000);
    check("async rst ee", ee, 4'b0000);
    i = 4'b0000;
    #1;
    check("async rst ne", ne, 4'b0000);
    i   = 4'b1111;
    rst = 1'b0;
    #1;
    check("async release pe", pe, 4'b1111);

    // glitch between capturing edges leaves no flag
    @(posedge clk);
    #1 i = 4'b0000;
    @(posedge clk);
    #1 i = 4'b0001;
    #1 i = 4'b0000;
    @(posedge clk);
    #1;
    check("glitch pe", pe, 4'b0000);
    check("glitch ne", ne, 4'b0000);
    check("glitch ee", ee, 4'b0000);
`else
    // synchronized build: flag appears two clocks after the input change
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 i = 4'b0001;
    #2;
    check("sync c0 pe", pe, 4'b0000);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #3;
      check($sformatf("sync c%0d pe", c), pe, (c == 2) ? 4'b0001 : 4'b0000);
      check($sformatf("sync c%0d ee", c), ee, (c == 2) ? 4'b0001 : 4'b0000);
    end
`endif

    // randomized run against the model, starting from a reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    for (int k = 0; k < 400; k++) begin
      logic [W-1:0] s;
      @(posedge clk);
      m_edge();
      #1;
      rst = ($urandom_range(0, 29) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      i   = W'($urandom);
      if (rst) m_reset();
      #2;
      s = m_src();
      check("rnd pe", pe, rst ? '0 : (s & ~m_hist));
      check("rnd ne", ne, rst ? '0 : (~s & m_hist));
      check("rnd ee", ee, rst ? '0 : (s ^ m_hist));
      check("rnd pe&ne", pe & ne, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
